// File: rtl/rv_core_pkg.sv
// Shared core types: XLEN constants, fetch-queue entry and fetch-unit state.
package rv_core_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } ifu_entry_t;

  typedef enum logic {
    IFU_RUN  = 1'b0,
    IFU_HALT = 1'b1
  } ifu_state_t;

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous prefetch FIFO of {pc, instr} entries; flush beats push and pop.
module ifu_fifo
  import rv_core_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic            i_flush,
  input  ifu_entry_t      i_wdata,
  output ifu_entry_t      o_rdata,
  output logic            o_full,
  output logic            o_empty,
  output logic [CW-1:0]   o_count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  ifu_entry_t      r_mem [DEPTH];
  logic [AW-1:0]   r_head;
  logic [AW-1:0]   r_tail;
  logic [CW-1:0]   r_count;

  // Storage is cleared on reset so the head reads as zero until the first push.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_tail] <= i_wdata;
        r_tail        <= r_tail + AW'(1);
      end
      if (i_pop) begin
        r_head <= r_head + AW'(1);
      end
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  assign o_rdata = r_mem[r_head];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, fills the prefetch FIFO, handles redirects.
// Optional misaligned-redirect trap enabled by defining IFU_MISALIGN_CHK_EN.
module instr_fetch_unit
  import rv_core_pkg::*;
#(
  parameter logic [31:0]  RESET_PC   = 32'h0000_0000,
  parameter int unsigned  FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
`ifdef IFU_MISALIGN_CHK_EN
  ,
  output logic        out_misalign
`endif
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  logic [31:0]    r_fetch_pc;
  ifu_state_t     r_state;
  logic           w_push;
  logic           w_pop;
  logic           w_full;
  logic           w_empty;
  logic [CW-1:0]  w_count;
  ifu_entry_t     w_wdata;
  ifu_entry_t     w_rdata;

  assign imem_addr = r_fetch_pc;
  assign w_pop     = !w_empty && out_ready;
  assign w_push    = (r_state == IFU_RUN) && !redirect_valid && (!w_full || w_pop);
  assign w_wdata   = '{pc: r_fetch_pc, instr: imem_instr};

  ifu_fifo #(
    .DEPTH   (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign out_valid = (w_count != '0);
  assign out_pc    = w_rdata.pc;
  assign out_instr = w_rdata.instr;

`ifdef IFU_MISALIGN_CHK_EN
  logic r_misalign;
  assign out_misalign = r_misalign;

  // A misaligned redirect parks the unit in HALT until an aligned redirect arrives.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_state    <= IFU_RUN;
      r_misalign <= 1'b0;
    end else if (redirect_valid) begin
      if (redirect_pc[1:0] != 2'b00) begin
        r_state    <= IFU_HALT;
        r_misalign <= 1'b1;
      end else begin
        r_state    <= IFU_RUN;
        r_misalign <= 1'b0;
        r_fetch_pc <= redirect_pc;
      end
    end else if (w_push) begin
      r_fetch_pc <= r_fetch_pc + 32'(INSTR_BYTES);
    end
  end
`else
  // Low address bits of a redirect are dropped so fetch stays word-aligned.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_state    <= IFU_RUN;
    end else if (redirect_valid) begin
      r_state    <= IFU_RUN;
      r_fetch_pc <= redirect_pc & ~32'(3);
    end else if (w_push) begin
      r_fetch_pc <= r_fetch_pc + 32'(INSTR_BYTES);
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; instruction memory returns the word index.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
`ifdef IFU_MISALIGN_CHK_EN
  logic        out_misalign;
`endif

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  always #5 clk = ~clk;

  assign imem_instr = {19'd0, imem_addr[14:2]};

  instr_fetch_unit #(
    .RESET_PC       (32'h0000_0000),
    .FIFO_DEPTH     (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr)
`ifdef IFU_MISALIGN_CHK_EN
    ,
    .out_misalign   (out_misalign)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    out_ready = 1'b1;
    do_reset();
    rst_n = 1'b0;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_pc",    out_pc,         32'd0);
    chk("rst_instr", out_instr,      32'd0);
    chk("rst_addr",  imem_addr,      32'd0);
`ifdef IFU_MISALIGN_CHK_EN
    chk("rst_misalign", 32'(out_misalign), 32'd0);
`endif
    rst_n = 1'b1;

    // Streaming at one instruction per cycle
    for (int k = 0; k < 6; k++) begin
      step();
      chk("s1_valid", 32'(out_valid), 32'd1);
      chk("s1_pc",    out_pc,         32'(4 * k));
      chk("s1_instr", out_instr,      32'(k));
    end

    // Back-pressure: queue fills, fetch address stalls at 0x10
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 10; k++) step();
    chk("s2_addr",  imem_addr,      32'h10);
    chk("s2_valid", 32'(out_valid), 32'd1);
    chk("s2_count", 32'(dut.w_count), 32'd4);
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("s2_pc",    out_pc,    32'(4 * k));
      chk("s2_instr", out_instr, 32'(k));
      step();
    end

    // Redirect with three entries queued; pop in the same cycle is ignored
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) step();
    chk("s3_addr_pre", imem_addr, 32'h0C);
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0;
    chk("s3_valid0", 32'(out_valid), 32'd0);
    chk("s3_addr",   imem_addr,      32'h100);
    step();
    chk("s3_valid1", 32'(out_valid), 32'd1);
    chk("s3_pc0",    out_pc,         32'h100);
    chk("s3_instr0", out_instr,      32'h40);
    step();
    chk("s3_pc1",    out_pc,         32'h104);

    // Back-to-back redirects: last wins
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    step();
    chk("s4_valid_a", 32'(out_valid), 32'd0);
    redirect_pc = 32'h80;
    step();
    redirect_valid = 1'b0;
    chk("s4_valid_b", 32'(out_valid), 32'd0);
    step();
    chk("s4_pc",    out_pc,    32'h80);
    chk("s4_instr", out_instr, 32'h20);

    // PC wrap at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    step();
    chk("s5_pc0",    out_pc,    32'hFFFF_FFF8);
    chk("s5_instr0", out_instr, 32'h1FFE);
    step();
    chk("s5_pc1",    out_pc,    32'hFFFF_FFFC);
    step();
    chk("s5_pc2",    out_pc,    32'h0000_0000);
    chk("s5_instr2", out_instr, 32'h0);

    // Reset in the middle of streaming
    rst_n = 1'b0;
    step();
    chk("s7_valid", 32'(out_valid), 32'd0);
    chk("s7_addr",  imem_addr,      32'd0);
    chk("s7_pc",    out_pc,         32'd0);
    rst_n = 1'b1;
    step();
    chk("s7_pc_after", out_pc, 32'd0);
    chk("s7_valid_after", 32'(out_valid), 32'd1);

`ifdef IFU_MISALIGN_CHK_EN
    // Misaligned redirect halts fetch until an aligned redirect
    redirect_valid = 1'b1;
    redirect_pc = 32'h300;
    step();
    redirect_valid = 1'b0;
    step();
    chk("s6_pc_pre", out_pc, 32'h300);
    redirect_valid = 1'b1;
    redirect_pc = 32'h102;
    step();
    redirect_valid = 1'b0;
    chk("s6_mis",   32'(out_misalign), 32'd1);
    chk("s6_valid", 32'(out_valid),    32'd0);
    chk("s6_addr",  imem_addr,         32'h304);
    for (int k = 0; k < 3; k++) step();
    chk("s6_addr_hold",  imem_addr,      32'h304);
    chk("s6_valid_hold", 32'(out_valid), 32'd0);
    chk("s6_mis_hold",   32'(out_misalign), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    step();
    redirect_valid = 1'b0;
    chk("s6_mis_clr", 32'(out_misalign), 32'd0);
    chk("s6_addr2",   imem_addr,         32'h200);
    step();
    chk("s6_valid2",  32'(out_valid), 32'd1);
    chk("s6_pc2",     out_pc,         32'h200);
`else
    // Unaligned redirect target has its low bits dropped
    redirect_valid = 1'b1;
    redirect_pc = 32'h10A;
    step();
    redirect_valid = 1'b0;
    chk("s6_addr", imem_addr, 32'h108);
    step();
    chk("s6_pc",    out_pc,    32'h108);
    chk("s6_instr", out_instr, 32'h42);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
